mul_seq: RTL
============

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-004 SHALL have port a, input, 32 (word_t), multiplicand; captured on accepted start.
REQ-005 SHALL have port b, input, 32 (word_t), multiplier; captured on accepted start.
REQ-006 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-007 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port product, output, 32 (word_t), low 32 bits of a*b; held until the next accepted start.
REQ-009 SHALL have port aluop, output, aluop_t, ALU operation select (initiator side of the ALU port set).
REQ-010 SHALL have port portA, output, 32, ALU operand A.
REQ-011 SHALL have port portB, output, 32, ALU operand B.
REQ-012 SHALL have port outputPort, input, 32, ALU result (combinational, same cycle).
REQ-013 SHALL have ports negative, zero and overflow, input, 1 each; ALU flags; accepted and ignored.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE, start=1: load mcand=a, mplier=b, acc=0; go to RUN if b!=0, else go directly to DONE.
REQ-016 IDLE, start=0: hold all registers.
REQ-017 RUN, combinational drive every cycle: aluop=ALU_ADD, portA=acc, portB=mcand.
REQ-018 RUN, each edge: if mplier[0]=1, acc<=outputPort; mcand<=mcand<<1; mplier<=mplier>>1 (logical); step count increments.
REQ-019 RUN exit: go to DONE when (mplier>>1)==0 or on the 32nd RUN cycle; the RUN cycle count equals the bit position of the MSB of b plus 1.
REQ-020 DONE: done=1 for exactly one cycle; product<=acc captured on entry; then go to IDLE unconditionally.
REQ-021 Arithmetic SHALL be modulo 2^32; the result is identical for signed and unsigned operands; ALU overflow SHALL NOT affect the result.
REQ-022 start while busy SHALL be ignored, with no queuing.
REQ-023 Outside RUN, aluop SHALL be ALU_ADD and portA/portB SHALL be 0.
REQ-024 Latency from the start edge to done high SHALL be (MSB index of b + 1) RUN cycles plus 1; b=0 gives done in the cycle after start.

Reset
REQ-025 RST=1 SHALL force IDLE, busy=0, done=0, product=0, acc/mcand/mplier=0, aluop=ALU_ADD, portA=portB=0, asynchronously.
REQ-026 RST asserted mid-RUN SHALL abort the operation with no done pulse; the first start after RST deassertion SHALL be accepted normally.

Structure
REQ-027 aluop_t, ALU_ADD and word_t SHALL come from cpu_types_pkg; the FSM state enum SHALL be local to mul_seq.
REQ-028 The ALU SHALL be external: the top level SHALL connect mul_seq to an alu instance through alu_if, with mul_seq driving aluop/portA/portB.
REQ-029 No other sub-module SHALL be used; the bench instantiates mul_seq plus alu.

Verification
REQ-030 a=3, b=5 -> 3 RUN cycles; done high in cycle 4 after start; product=15.
REQ-031 a=0x12345678, b=0 -> done in cycle 1 after start; product=0; aluop stays ALU_ADD with ports 0.
REQ-032 a=0xFFFFFFFF, b=0xFFFFFFFF -> 32 RUN cycles; product=0x00000001; ALU overflow pulses ignored.
REQ-033 a=-7 (0xFFFFFFF9), b=6 -> product=0xFFFFFFD6 (-42); a second start pulsed mid-RUN is ignored and yields a single done.
REQ-034 RST asserted in RUN cycle 2 of a=9, b=0x80000000 -> immediate IDLE, product=0, no done; then a=4, b=4 -> product=16.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and ALU operation encodings.
package cpu_types_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10
   } aluop_t;

   // Signed overflow of s = x + y; pass ~y to get the x - y case.
   function automatic logic add_ovf(word_t x, word_t y, word_t s);
      return (x[XLEN-1] == y[XLEN-1]) &&
             (s[XLEN-1] != x[XLEN-1]);
   endfunction

endpackage

// File: rtl/alu_if.sv
// ALU port set: initiator drives op and operands, ALU returns result and flags.
interface alu_if;
   import cpu_types_pkg::*;

   aluop_t aluop;
   word_t  portA;
   word_t  portB;
   word_t  outputPort;
   logic   negative;
   logic   zero;
   logic   overflow;

   modport master (
      output aluop,
      output portA,
      output portB,
      input  outputPort,
      input  negative,
      input  zero,
      input  overflow
   );

   modport slave (
      input  aluop,
      input  portA,
      input  portB,
      output outputPort,
      output negative,
      output zero,
      output overflow
   );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU; result and flags follow the operands
// within the same cycle.
module alu
   import cpu_types_pkg::*;
(
   alu_if.slave bus
);

   word_t x;
   word_t y;
   word_t r;
   logic  ovf;

   assign x = bus.portA;
   assign y = bus.portB;

   always_comb begin
      r   = '0;
      ovf = 1'b0;
      unique case (bus.aluop)
         ALU_ADD: begin
            r   = x + y;
            ovf = add_ovf(x, y, r);
         end
         ALU_SUB: begin
            r   = x - y;
            ovf = add_ovf(x, ~y, r);
         end
         ALU_AND:   r = x & y;
         ALU_OR:    r = x | y;
         ALU_XOR:   r = x ^ y;
         ALU_SLL:   r = x << y[4:0];
         ALU_SRL:   r = x >> y[4:0];
         ALU_SRA:   r = word_t'($signed(x) >>> y[4:0]);
         ALU_SLT:   r = {{(XLEN-1){1'b0}},
                         $signed(x) < $signed(y)};
         ALU_SLTU:  r = {{(XLEN-1){1'b0}}, x < y};
         ALU_PASSB: r = y;
         default:   r = '0;
      endcase
   end

   assign bus.outputPort = r;
   assign bus.negative   = r[XLEN-1];
   assign bus.zero       = (r == '0);
   assign bus.overflow   = ovf;

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier (low 32 bits of a*b) that borrows
// an external ALU for its additions, one multiplier bit per cycle.
module mul_seq
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  start,
   input  word_t a,
   input  word_t b,
   output logic  busy,
   output logic  done,
   output word_t product,
   alu_if.master alu
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   word_t      acc;
   word_t      mcand;
   word_t      mplier;
   logic [4:0] cnt;
   logic       last;
   word_t      acc_nxt;
   logic       unused_flags;

   // Flags never influence the result; wrap-around is the intended math.
   assign unused_flags = ^{alu.negative, alu.zero, alu.overflow};

   assign last    = (mplier[XLEN-1:1] == '0) || (cnt == 5'd31);
   assign acc_nxt = mplier[0] ? alu.outputPort : acc;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (b == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      alu.aluop = ALU_ADD;
      alu.portA = '0;
      alu.portB = '0;
      unique case (state)
         IDLE: begin
         end
         RUN: begin
            busy      = 1'b1;
            alu.portA = acc;
            alu.portB = mcand;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Product is latched on the edge entering DONE so it is valid with done.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  acc    <= '0;
                  mcand  <= a;
                  mplier <= b;
                  cnt    <= '0;
                  if (b == '0) begin
                     product <= '0;
                  end
               end
            end
            RUN: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
               if (last) begin
                  product <= acc_nxt;
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule
